// File: rtl/ppi_sync_ports_if.sv
// CPU-side register bus of the ppi_sync_ports peripheral.
// The master drives the strobes, address and write data. The slave returns read data and the bus drive enable.
interface ppi_sync_ports_if #(
    parameter int PORT_W = 8,
    parameter int ADDR_W = 3
);
    logic              cs_n;
    logic              rd_n;
    logic              wr_n;
    logic [ADDR_W-1:0] addr;
    logic [PORT_W-1:0] din;
    logic [PORT_W-1:0] dout;
    logic              dout_oe;

    modport master (output cs_n, rd_n, wr_n, addr, din, input dout, dout_oe);
    modport slave  (input cs_n, rd_n, wr_n, addr, din, output dout, dout_oe);
endinterface

// File: rtl/ppi_sync_ports.sv
// Synchronous multi-port PPI: general-purpose ports with direction registers, a strobed input on port 0 and a strobed output on port 1.
// Optional macro PPI_BSR_EN makes a write to STATUS perform a bit set/reset on the last port.
module ppi_sync_ports #(
    parameter int PORT_W    = 8,
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    ppi_sync_ports_if.slave               bus,
    input  logic [NUM_PORTS*PORT_W-1:0]   port_in,
    output logic [NUM_PORTS*PORT_W-1:0]   port_out,
    output logic [NUM_PORTS*PORT_W-1:0]   port_oe,
    input  logic                          stb_n,
    output logic                          ibf,
    input  logic                          ack_n,
    output logic                          obf_n,
    output logic                          intr
);

    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(2*NUM_PORTS);
    localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(2*NUM_PORTS+1);

    typedef logic [NUM_PORTS-1:0][PORT_W-1:0] port_vec_t;

    logic              rd_act_q, rd_act_d, wr_act_q, wr_act_d;
    logic              rd_prev_q, rd_prev_d, wr_prev_q, wr_prev_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PORT_W-1:0] din_q, din_d;
    port_vec_t         port_in_q, port_in_d;
    port_vec_t         data_q, data_d;
    port_vec_t         dir_q, dir_d;
    logic [3:0]        ctrl_q, ctrl_d;
    logic [PORT_W-1:0] latch_a_q, latch_a_d;
    logic              ibf_q, ibf_d, obf_n_q, obf_n_d, intr_q, intr_d;
    logic [PORT_W-1:0] dout_q, dout_d;
    logic              stb_s1_q, stb_s1_d, stb_s2_q, stb_s2_d, stb_prev_q, stb_prev_d;
    logic              ack_s1_q, ack_s1_d, ack_s2_q, ack_s2_d, ack_prev_q, ack_prev_d;

    logic              rd_fire, wr_fire, stb_fall, ack_fall;
    logic              mode_a, mode_b, intr_a, intr_b;
    logic [PORT_W-1:0] rd_data;

    // Bus strobes are single-shot: only the first registered active cycle acts
    assign rd_fire  = rd_act_q & ~rd_prev_q;
    assign wr_fire  = wr_act_q & ~wr_prev_q;
    assign stb_fall = stb_prev_q & ~stb_s2_q;
    assign ack_fall = ack_prev_q & ~ack_s2_q;
    assign mode_a   = ctrl_q[0];
    assign mode_b   = ctrl_q[1];
    assign intr_a   = mode_a & ctrl_q[2] & ibf_q;
    assign intr_b   = mode_b & ctrl_q[3] & obf_n_q;

    always_comb begin
        rd_act_d   = ~bus.cs_n & ~bus.rd_n;
        wr_act_d   = ~bus.cs_n & ~bus.wr_n;
        rd_prev_d  = rd_act_q;
        wr_prev_d  = wr_act_q;
        addr_d     = bus.addr;
        din_d      = bus.din;
        port_in_d  = port_in;
        stb_s1_d   = stb_n;
        stb_s2_d   = stb_s1_q;
        stb_prev_d = stb_s2_q;
        ack_s1_d   = ack_n;
        ack_s2_d   = ack_s1_q;
        ack_prev_d = ack_s2_q;
        data_d     = data_q;
        dir_d      = dir_q;
        ctrl_d     = ctrl_q;
        latch_a_d  = latch_a_q;
        ibf_d      = ibf_q;
        obf_n_d    = obf_n_q;
        dout_d     = dout_q;
        rd_data    = '0;

        for (int i = 0; i < NUM_PORTS; i++) begin
            if (addr_q == ADDR_W'(i))
                rd_data = (data_q[i] & dir_q[i]) | (port_in_q[i] & ~dir_q[i]);
            if (addr_q == ADDR_W'(NUM_PORTS + i))
                rd_data = dir_q[i];
        end
        if (addr_q == '0 && mode_a)
            rd_data = latch_a_q;
        if (addr_q == CTRL_ADDR)
            rd_data = PORT_W'(ctrl_q);
        if (addr_q == STAT_ADDR)
            rd_data = PORT_W'({intr_b, intr_a, ~obf_n_q, ibf_q});
        if (rd_fire)
            dout_d = rd_data;

        if (wr_fire) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (addr_q == ADDR_W'(i))
                    data_d[i] = din_q;
                if (addr_q == ADDR_W'(NUM_PORTS + i))
                    dir_d[i] = din_q;
            end
            if (addr_q == CTRL_ADDR)
                ctrl_d = din_q[3:0];
`ifdef PPI_BSR_EN
            // Out-of-range bit indices simply match no bit of the port
            if (addr_q == STAT_ADDR) begin
                for (int b = 0; b < PORT_W; b++) begin
                    if (din_q[$clog2(PORT_W):1] == ($clog2(PORT_W))'(b))
                        data_d[NUM_PORTS-1][b] = din_q[0];
                end
            end
`endif
        end

        // A strobe edge beats a coincident clearing read
        if (!mode_a) begin
            ibf_d = 1'b0;
        end else if (stb_fall) begin
            ibf_d     = 1'b1;
            latch_a_d = port_in_q[0];
        end else if (rd_fire && addr_q == '0) begin
            ibf_d = 1'b0;
        end

        // A write beats a coincident acknowledge
        if (!mode_b)
            obf_n_d = 1'b1;
        else if (wr_fire && addr_q == ADDR_W'(1))
            obf_n_d = 1'b0;
        else if (ack_fall)
            obf_n_d = 1'b1;

        intr_d = (ctrl_d[0] & ctrl_d[2] & ibf_d) | (ctrl_d[1] & ctrl_d[3] & obf_n_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_act_q   <= 1'b0;
            wr_act_q   <= 1'b0;
            rd_prev_q  <= 1'b0;
            wr_prev_q  <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            port_in_q  <= '0;
            data_q     <= '0;
            dir_q      <= '0;
            ctrl_q     <= '0;
            latch_a_q  <= '0;
            ibf_q      <= 1'b0;
            obf_n_q    <= 1'b1;
            intr_q     <= 1'b0;
            dout_q     <= '0;
            stb_s1_q   <= 1'b1;
            stb_s2_q   <= 1'b1;
            stb_prev_q <= 1'b1;
            ack_s1_q   <= 1'b1;
            ack_s2_q   <= 1'b1;
            ack_prev_q <= 1'b1;
        end else begin
            rd_act_q   <= rd_act_d;
            wr_act_q   <= wr_act_d;
            rd_prev_q  <= rd_prev_d;
            wr_prev_q  <= wr_prev_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            port_in_q  <= port_in_d;
            data_q     <= data_d;
            dir_q      <= dir_d;
            ctrl_q     <= ctrl_d;
            latch_a_q  <= latch_a_d;
            ibf_q      <= ibf_d;
            obf_n_q    <= obf_n_d;
            intr_q     <= intr_d;
            dout_q     <= dout_d;
            stb_s1_q   <= stb_s1_d;
            stb_s2_q   <= stb_s2_d;
            stb_prev_q <= stb_prev_d;
            ack_s1_q   <= ack_s1_d;
            ack_s2_q   <= ack_s2_d;
            ack_prev_q <= ack_prev_d;
        end
    end

    assign port_out    = data_q;
    assign port_oe     = dir_q;
    assign ibf         = ibf_q;
    assign obf_n       = obf_n_q;
    assign intr        = intr_q;
    assign bus.dout    = dout_q;
    assign bus.dout_oe = rd_act_q;

endmodule

// File: doc/ppi_sync_ports.md
Name: ppi_sync_ports

Overview:
Parametrised, fully synchronous successor to the team's mode-0 8255-style programmable peripheral interface. Provides NUM_PORTS general-purpose ports of PORT_W bits each, with per-bit direction registers. Port 0 supports a strobed-input handshake and port 1 a strobed-output handshake, both with interrupt generation. Sits between a CPU-style register bus and board-level I/O pins; the pad level resolves the tri-state pins from out/oe pairs.

Parameters:
PORT_W, 8, width of each port and of the data bus
NUM_PORTS, 3, number of ports; must be 2..(2**ADDR_W-2)/2
ADDR_W, 3, address width

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  synchronous active-high reset
cs_n  input  1  chip select, active low
rd_n  input  1  read strobe, active low, level from CPU
wr_n  input  1  write strobe, active low, level from CPU
addr  input  ADDR_W  register address
din  input  PORT_W  write data
dout  output  PORT_W  read data
dout_oe  output  1  data bus drive enable
port_in  input  NUM_PORTS*PORT_W  pin inputs, port i at [i*PORT_W +: PORT_W]
port_out  output  NUM_PORTS*PORT_W  pin output values
port_oe  output  NUM_PORTS*PORT_W  per-bit output enable, 1 = drive
stb_n  input  1  port 0 input strobe, async, active low
ibf  output  1  port 0 input buffer full
ack_n  input  1  port 1 acknowledge, async, active low
obf_n  output  1  port 1 output buffer full, active low
intr  output  1  interrupt request, level

Behaviour:
- Reset (synchronous, active-high): port_out=0, port_oe=0 (all inputs), DIR=0, CTRL=0, ibf=0, obf_n=1, intr=0, dout=0, dout_oe=0, strobe-edge history=idle (high).
- Address map: i = DATA[i]; NUM_PORTS+i = DIR[i] (1 = output bit); 2*NUM_PORTS = CTRL; 2*NUM_PORTS+1 = STATUS (read-only). Unmapped addresses read 0; writes to them are ignored.
- CTRL bits: [0] mode_a (port 0 strobed input), [1] mode_b (port 1 strobed output), [2] ie_a, [3] ie_b; upper bits read 0.
- STATUS: [0] ibf, [1] ~obf_n, [2] intr_a, [3] intr_b; upper bits read 0.
- Bus strobes are registered once; rd_n/wr_n are edge-detected internally. A write commits exactly once, on the first cycle a registered (cs_n=0 & wr_n=0) is seen after it was inactive. A held strobe never repeats the action.
- Read: dout_oe=1 while registered cs_n=0 & rd_n=0. dout is registered and valid the cycle after the read is detected. Read side effects fire once, on the first detected cycle.
- DATA[i] read: per bit, port_out if DIR bit=1, else port_in registered once (1-cycle sample). Exception: mode_a=1 returns the port 0 latch.
- DATA[i] write: updates port_out[i]. Bits with DIR=0 store the value but do not drive it. port_oe[i]=DIR[i].
- Strobed input (mode_a=1): stb_n is passed through a 2-flop synchroniser. Its falling edge latches port_in[0] and sets ibf the next cycle. A DATA[0] read clears ibf. If a stb edge and a read coincide, set wins and the latch takes the new data. A stb edge while ibf=1 overwrites the latch.
- Strobed output (mode_b=1): a DATA[1] write drives obf_n=0 the next cycle. A synchronised ack_n falling edge sets obf_n=1. An ack while obf_n=1 is ignored. A write while obf_n=0 updates the data and keeps obf_n=0. If a write and an ack coincide, the write wins (obf_n=0).
- intr_a = mode_a & ie_a & ibf. intr_b = mode_b & ie_b & obf_n. intr = intr_a | intr_b, registered.
- Clearing mode_a or mode_b forces ibf=0 or obf_n=1 respectively on the next cycle.
- Reset asserted mid-handshake aborts it; all state returns to the reset values.

Optional Feature:
PPI_BSR_EN
- Defined: a write to the STATUS address performs a bit set/reset on port NUM_PORTS-1. Bit index = din[clog2(PORT_W):1], value = din[0]. Only the addressed port_out bit changes; an index >= PORT_W is ignored. The write affects only port_out, not port_oe.
- Undefined: writes to STATUS are ignored.

Test Plan:
- Reset, then read DIR[0..2] and CTRL -> 0; port_oe=0; ibf=0; obf_n=1; intr=0.
- Write DIR[0]=0xF0, DATA[0]=0xA5, port_in[0]=0x3C -> port_oe[0]=0xF0; port_out[0]=0xA5; DATA[0] reads 0xAC.
- CTRL=0x05, pulse stb_n low with port_in[0]=0x98 -> ibf=1 and intr=1 within 4 cycles; read DATA[0]=0x98; ibf=0 and intr=0 after the read.
- CTRL=0x0A, DIR[1]=0xFF, write DATA[1]=0x67 -> obf_n=0 next cycle, intr=0; pulse ack_n -> obf_n=1, intr=1.
- wr_n held low 10 cycles writing DATA[1] in mode_b, then ack -> obf_n=1 and stays 1 (single commit per strobe).
- PPI_BSR_EN defined, DIR[2]=0xFF: write STATUS=0x07 -> port_out[2] bit3=1; write 0x06 -> bit3=0; other bits unchanged.
